// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request feeding a 2-entry
// {PC, IR} buffer that decode drains; a redirect flushes and retargets fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_PC,
    input  logic        id_stall,
    output logic        proc2Imem_req,
    output logic [31:0] proc2Imem_addr,
    input  logic        Imem2proc_ready,
    input  logic        Imem2proc_valid,
    input  logic [31:0] Imem2proc_data,
    output logic        if_id_valid_inst,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    output logic [31:0] if_id_IR
);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_buf_pc [2];
    logic [31:0] r_buf_ir [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_outstanding;
    logic        r_drop;

    logic        w_pop;
    logic        w_push;
    logic        w_accept;
    logic        w_tail;
    logic [2:0]  w_occ_after_pop;
    logic [1:0]  w_unused_tgt;

    assign w_unused_tgt = ex_target_PC[1:0];

    assign if_id_valid_inst = (r_count != 2'd0);
    assign if_id_PC         = if_id_valid_inst ? r_buf_pc[r_head] : 32'h0000_0000;
    assign if_id_NPC        = if_id_PC + 32'd4;
    assign if_id_IR         = if_id_valid_inst ? r_buf_ir[r_head] : NOP_INST;

    assign w_pop  = if_id_valid_inst & ~id_stall;
    assign w_push = Imem2proc_valid & ~r_drop & ~ex_take_branch;
    assign w_tail = r_head ^ r_count[0];

    // Occupancy counts the in-flight request as already buffered, so a new
    // request is only issued when its response is guaranteed a free slot.
    assign w_occ_after_pop = {1'b0, r_count} + {2'b00, r_outstanding} - {2'b00, w_pop};
    assign proc2Imem_req   = rst & ~ex_take_branch & (~r_outstanding | Imem2proc_valid)
                           & (w_occ_after_pop < 3'd2);
    assign proc2Imem_addr  = r_fetch_pc;
    assign w_accept        = proc2Imem_req & Imem2proc_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (ex_take_branch) begin
            r_fetch_pc <= {ex_target_PC[31:2], 2'b00};
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            // A request still in flight stays outstanding but its data is marked stale.
            if (Imem2proc_valid) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end else begin
                r_drop <= r_outstanding;
            end
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_req_pc   <= r_fetch_pc;
            end
            if (Imem2proc_valid) begin
                r_outstanding <= w_accept;
                r_drop        <= 1'b0;
            end else if (w_accept) begin
                r_outstanding <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[w_tail] <= r_req_pc;
            r_buf_ir[w_tail] <= Imem2proc_data;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(w_push && (r_count == 2'd2)));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-randomised memory model, program-order stream
// reference kept in an expected queue, and a negedge monitor that checks deliveries.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_take_branch;
    logic [31:0] ex_target_PC;
    logic        id_stall;
    logic        proc2Imem_req;
    logic [31:0] proc2Imem_addr;
    logic        Imem2proc_ready;
    logic        Imem2proc_valid;
    logic [31:0] Imem2proc_data;
    logic        if_id_valid_inst;
    logic [31:0] if_id_PC;
    logic [31:0] if_id_NPC;
    logic [31:0] if_id_IR;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_take_branch   (ex_take_branch),
        .ex_target_PC     (ex_target_PC),
        .id_stall         (id_stall),
        .proc2Imem_req    (proc2Imem_req),
        .proc2Imem_addr   (proc2Imem_addr),
        .Imem2proc_ready  (Imem2proc_ready),
        .Imem2proc_valid  (Imem2proc_valid),
        .Imem2proc_data   (Imem2proc_data),
        .if_id_valid_inst (if_id_valid_inst),
        .if_id_PC         (if_id_PC),
        .if_id_NPC        (if_id_NPC),
        .if_id_IR         (if_id_IR)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv = 0;
    int cyc     = 0;

    // Expected decode stream: {PC, IR} in program order from the last redirect/reset.
    logic [63:0] exp_q[$];
    logic [31:0] next_pc;

    int ready_mode = 1;  // 0 random, 1 always ready, 2 never ready
    int lat_min    = 1;
    int lat_max    = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({next_pc, mem_word(next_pc)});
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic set_stream(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic do_branch(input logic [31:0] tgt);
        ex_take_branch = 1'b1;
        ex_target_PC   = tgt;
        set_stream({tgt[31:2], 2'b00});
    endtask

    task automatic check_reset_outputs(input string tag);
        check1 ({tag, "_valid"}, if_id_valid_inst, 1'b0);
        check32({tag, "_ir"},    if_id_IR,  NOP_INST);
        check32({tag, "_pc"},    if_id_PC,  32'h0);
        check32({tag, "_npc"},   if_id_NPC, 32'h4);
        check1 ({tag, "_req"},   proc2Imem_req, 1'b0);
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        ex_take_branch = 1'b0;
        id_stall       = 1'b0;
        set_stream(RESET_PC);
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b1;
    endtask

    // Memory model: in-order responses, latency lat_min..lat_max cycles after acceptance.
    initial begin
        logic        s_acc;
        logic        s_resp;
        logic        s_rst;
        logic [31:0] s_addr;
        pend_t       p;
        Imem2proc_valid = 1'b0;
        Imem2proc_data  = 32'h0;
        Imem2proc_ready = 1'b0;
        forever begin
            @(negedge clk);
            s_rst  = rst;
            s_acc  = rst && proc2Imem_req && Imem2proc_ready;
            s_addr = proc2Imem_addr;
            s_resp = Imem2proc_valid;
            @(posedge clk);
            #1;
            if (!s_rst) begin
                pend_q.delete();
            end else begin
                if (s_resp && pend_q.size() != 0) void'(pend_q.pop_front());
                if (s_acc) begin
                    p.addr = s_addr;
                    p.due  = cyc + int'($urandom_range(lat_min, lat_max)) - 1;
                    pend_q.push_back(p);
                end
            end
            if (s_rst && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                Imem2proc_valid = 1'b1;
                Imem2proc_data  = mem_word(pend_q[0].addr);
            end else begin
                Imem2proc_valid = 1'b0;
                Imem2proc_data  = $urandom;
            end
            case (ready_mode)
                1:       Imem2proc_ready = 1'b1;
                2:       Imem2proc_ready = 1'b0;
                default: Imem2proc_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: every delivered instruction must be the next one in program order.
    initial begin
        logic        p_req;
        logic        p_rdy;
        logic [31:0] p_addr;
        logic [63:0] e;
        p_req  = 1'b0;
        p_rdy  = 1'b0;
        p_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ex_take_branch) check1("req_low_on_branch", proc2Imem_req, 1'b0);
                if (proc2Imem_req) check32("addr_aligned", {30'b0, proc2Imem_addr[1:0]}, 32'h0);
                if (p_req && !p_rdy && proc2Imem_req)
                    check32("addr_hold", proc2Imem_addr, p_addr);
                if (!if_id_valid_inst) begin
                    check32("nop_when_invalid", if_id_IR, NOP_INST);
                end else if (!id_stall && !ex_take_branch) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL deliver_empty_q: got pc %h expected nothing", if_id_PC);
                    end else begin
                        e = exp_q.pop_front();
                        check32("deliver_pc",  if_id_PC,  e[63:32]);
                        check32("deliver_ir",  if_id_IR,  e[31:0]);
                        check32("deliver_npc", if_id_NPC, e[63:32] + 32'd4);
                        n_deliv++;
                    end
                end
                p_req  = proc2Imem_req;
                p_rdy  = Imem2proc_ready;
                p_addr = proc2Imem_addr;
            end else begin
                p_req = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        logic        found;
        logic [31:0] hold_pc;
        rst            = 1'b0;
        ex_take_branch = 1'b0;
        ex_target_PC   = 32'h0;
        id_stall       = 1'b0;
        next_pc        = RESET_PC;

        // Streaming after reset: one address per cycle, first instruction in cycle 3.
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check1 ("stream_req", proc2Imem_req, 1'b1);
            check32("stream_addr", proc2Imem_addr, 32'(4 * (k - 1)));
            if (k < 3) begin
                check1("stream_early_invalid", if_id_valid_inst, 1'b0);
            end else begin
                check1 ("stream_valid", if_id_valid_inst, 1'b1);
                check32("stream_pc", if_id_PC, 32'(4 * (k - 3)));
            end
            tick();
        end
        d0 = n_deliv;
        repeat (20) tick();
        check32("throughput", 32'(n_deliv - d0), 32'd20);

        // Decode stall: buffer fills, requests stop, head held.
        id_stall = 1'b1;
        @(negedge clk);
        hold_pc = if_id_PC;
        check1("stall_valid", if_id_valid_inst, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        check1 ("stall_req_off", proc2Imem_req, 1'b0);
        check32("stall_pc_held", if_id_PC, hold_pc);
        tick();
        id_stall = 1'b0;
        repeat (10) tick();

        // Memory not ready: address 0x10 held for three cycles, accepted on the fourth.
        ready_mode = 2;
        apply_reset();
        do_branch(32'h0000_0013);
        tick();
        ex_take_branch = 1'b0;
        ex_target_PC   = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1 ("notready_req", proc2Imem_req, 1'b1);
            check32("notready_addr", proc2Imem_addr, 32'h10);
            if (k == 2) ready_mode = 1;
            tick();
        end
        @(negedge clk);
        check1 ("accept_ready", Imem2proc_ready, 1'b1);
        check32("accept_addr", proc2Imem_addr, 32'h10);
        tick();
        @(negedge clk);
        check32("after_accept_addr", proc2Imem_addr, 32'h14);
        repeat (8) tick();

        // Redirect while a request is outstanding: stale data dropped.
        lat_min = 3;
        lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (proc2Imem_req && Imem2proc_ready) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check1("outstanding_found", found, 1'b1);
        tick();
        do_branch(32'h0000_0103);
        @(negedge clk);
        check1("redirect_no_resp", Imem2proc_valid, 1'b0);
        tick();
        ex_take_branch = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (proc2Imem_req) begin
                found = 1'b1;
                check32("redirect_addr", proc2Imem_addr, 32'h100);
                break;
            end
            tick();
        end
        check1("redirect_req_seen", found, 1'b1);
        lat_min = 1;
        lat_max = 1;
        repeat (12) tick();

        // Redirect coinciding with a response and a pop.
        @(negedge clk);
        check1("coinc_resp", Imem2proc_valid, 1'b1);
        check1("coinc_head", if_id_valid_inst, 1'b1);
        tick();
        do_branch(32'h0000_2000);
        tick();
        ex_take_branch = 1'b0;
        @(negedge clk);
        check1 ("coinc_empty", if_id_valid_inst, 1'b0);
        check1 ("coinc_req", proc2Imem_req, 1'b1);
        check32("coinc_addr", proc2Imem_addr, 32'h2000);
        repeat (6) tick();

        // PC wrap across the top of the address space.
        do_branch(32'hFFFF_FFF4);
        tick();
        ex_take_branch = 1'b0;
        repeat (10) tick();

        // Asynchronous reset with a full buffer.
        id_stall = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check1("full_before_reset", if_id_valid_inst, 1'b1);
        check1("full_req_off", proc2Imem_req, 1'b0);
        @(posedge clk);
        #3;
        rst      = 1'b0;
        id_stall = 1'b0;
        set_stream(RESET_PC);
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check1 ("refetch_req", proc2Imem_req, 1'b1);
        check32("refetch_addr", proc2Imem_addr, RESET_PC);
        repeat (10) tick();

        // Randomised traffic: stalls, ready gaps, variable latency, redirects, resets.
        ready_mode = 0;
        lat_min    = 1;
        lat_max    = 3;
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            id_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst            = 1'b0;
                ex_take_branch = 1'b0;
                id_stall       = 1'b0;
                set_stream(RESET_PC);
                tick();
                tick();
                rst = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) do_branch(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                else do_branch($urandom);
            end else begin
                ex_take_branch = 1'b0;
                ex_target_PC   = $urandom;
            end
            tick();
        end
        ex_take_branch = 1'b0;
        id_stall       = 1'b0;
        repeat (10) tick();
        check1("random_progress", (n_deliv - d0) > 300, 1'b1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
